// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// path (port 0) and a secondary master (port 1). Round-robin arbitration with
// optional bounded locked bursts; read data is returned one cycle after grant.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              stall0,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Arbitration state: last granted port, whether that owner asked to keep
    // the bus, and how many consecutive locked grants it has had.
    logic             last;
    logic             owner_locked;
    logic [CNT_W-1:0] burst_cnt;

    logic             lock_active;
    logic             pick1;
    logic             grant_any;
    logic             grant_lock;
    logic             read_grant;
    logic [CNT_W-1:0] burst_cnt_next;

    // Pick a winner: lone requester always wins; on conflict the locked owner
    // keeps the bus until its burst budget runs out, otherwise round-robin.
    always_comb begin
        lock_active = owner_locked && (burst_cnt < BURST_MAX);
        pick1       = 1'b0;
        if (req0 && req1) begin
            pick1 = lock_active ? last : ~last;
        end else begin
            pick1 = req1;
        end
        gnt0 = ~rst & req0 & ~pick1;
        gnt1 = ~rst & req1 & pick1;
    end

    // Steer the granted port onto the memory bus; idle bus shows port 0.
    always_comb begin
        mem_addr   = gnt1 ? addr1  : addr0;
        mem_wdata  = gnt1 ? wdata1 : wdata0;
        mem_we     = (gnt0 & we0) | (gnt1 & we1);
        stall0     = req0 & ~gnt0;
        grant_any  = gnt0 | gnt1;
        grant_lock = gnt1 ? lock1 : lock0;
        read_grant = grant_any & ~mem_we;
    end

    // Burst counter advances only while the same locked owner keeps winning;
    // it saturates so a long lone burst never wraps back into lock range.
    always_comb begin
        burst_cnt_next = CNT_ONE;
        if ((gnt1 == last) && owner_locked) begin
            burst_cnt_next = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_ONE;
        end
    end

    // Update arbitration history and capture read data for the granted port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last         <= 1'b1;
            owner_locked <= 1'b0;
            burst_cnt    <= '0;
            rvalid0      <= 1'b0;
            rvalid1      <= 1'b0;
            rdata        <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (grant_any) begin
                last         <= gnt1;
                owner_locked <= grant_lock;
                burst_cnt    <= burst_cnt_next;
                if (read_grant) begin
                    rdata <= mem_rdata;
                end
            end else begin
                owner_locked <= 1'b0;
                burst_cnt    <= '0;
            end
        end
    end

endmodule
